// File: rtl/keypad_calc_controller.sv
// Keypad-to-ALU sequencer: debounces scanner levels into single key events and
// runs the two-operand entry FSM that launches one ALU operation per equals key.
module keypad_calc_controller #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int RELEASE_CYCLES  = 500000,
  parameter int ALU_TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [3:0]       row_index,
  input  logic [1:0]       col_index,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_err,
  output logic             alu_start,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  output logic             key_event,
  output logic [3:0]       key_code,
  output logic [WIDTH-1:0] disp_value,
  output logic             disp_err,
  output logic             busy
);
  localparam int HW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);
  localparam int TW = $clog2(ALU_TIMEOUT + 1);
  localparam int XW = WIDTH + 4;

  typedef enum logic [1:0] {ENTER_A, ENTER_B, WAIT, SHOW} state_e;

  logic [3:0]    code;
  logic [3:0]    held_q, held_d;
  logic [HW-1:0] hi_q, hi_d;
  logic [RW-1:0] rel_q, rel_d;
  logic          armed_q, armed_d;
  logic          kev_q, kev_d;
  logic [3:0]    kcode_q, kcode_d;
  logic          unused_row;

  assign code       = {row_index[1:0], col_index};
  assign unused_row = ^row_index[3:2];

  always_comb begin
    held_d  = held_q;
    hi_d    = hi_q;
    rel_d   = rel_q;
    armed_d = armed_q;
    kev_d   = 1'b0;
    kcode_d = kcode_q;
    if (rel_q == RW'(RELEASE_CYCLES)) begin
      hi_d    = '0;
      armed_d = 1'b1;
    end
    if (key_valid) begin
      rel_d = '0;
      if (code != held_q) begin
        held_d = code;
        hi_d   = HW'(1);
      end else if (hi_d != HW'(DEBOUNCE_CYCLES)) begin
        hi_d = hi_d + 1'b1;
      end
    end else if (rel_q != RW'(RELEASE_CYCLES)) begin
      rel_d = rel_q + 1'b1;
    end
    // Counter saturates, so the disarmed flag is what blocks repeats while held.
    if (armed_q && hi_q == HW'(DEBOUNCE_CYCLES)) begin
      kev_d   = 1'b1;
      kcode_d = held_q;
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q  <= '0;
      hi_q    <= '0;
      rel_q   <= '0;
      armed_q <= 1'b1;
      kev_q   <= 1'b0;
      kcode_q <= '0;
    end else begin
      held_q  <= held_d;
      hi_q    <= hi_d;
      rel_q   <= rel_d;
      armed_q <= armed_d;
      kev_q   <= kev_d;
      kcode_q <= kcode_d;
    end
  end

  logic [1:0]       krow, kcol;
  logic             is_digit, is_op, is_clr, is_eq, fits;
  logic [3:0]       dval;
  logic [WIDTH-1:0] acc_sel;
  logic [XW-1:0]    acc_x;

  always_comb begin
    krow     = kcode_q[3:2];
    kcol     = kcode_q[1:0];
    is_op    = (kcol == 2'd3);
    is_clr   = (kcode_q == 4'd12);
    is_eq    = (kcode_q == 4'd14);
    is_digit = (kcol != 2'd3 && krow != 2'd3) || (kcode_q == 4'd13);
    dval     = (kcode_q == 4'd13) ? 4'd0 : ({2'b00, krow} * 4'd3 + {2'b00, kcol} + 4'd1);
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic             bdig_q, bdig_d, err_q, err_d, start_q, start_d;
  logic [TW-1:0]    tmo_q, tmo_d;

  assign acc_sel = (state_q == ENTER_B) ? b_q : a_q;
  assign acc_x   = XW'(acc_sel) * XW'(10) + XW'(dval);
  assign fits    = (acc_x[XW-1:WIDTH] == '0);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    bdig_d  = bdig_q;
    err_d   = err_q;
    start_d = 1'b0;
    tmo_d   = tmo_q;
    case (state_q)
      ENTER_A, ENTER_B: if (kev_q) begin
        if (is_digit) begin
          if (fits) begin
            if (state_q == ENTER_A) a_d = acc_x[WIDTH-1:0];
            else begin
              b_d    = acc_x[WIDTH-1:0];
              bdig_d = 1'b1;
            end
          end
        end else if (is_op) begin
          if (state_q == ENTER_A) begin
            op_d    = krow;
            b_d     = '0;
            bdig_d  = 1'b0;
            state_d = ENTER_B;
          end else if (!bdig_q) begin
            op_d = krow;
          end
        end else if (is_eq) begin
          if (state_q == ENTER_B && bdig_q) begin
            state_d = WAIT;
            start_d = 1'b1;
            tmo_d   = '0;
          end
        end else if (is_clr) begin
          state_d = ENTER_A;
          a_d = '0; b_d = '0; op_d = '0; bdig_d = 1'b0; err_d = 1'b0;
        end
      end
      WAIT: begin
        // A done strobe coincident with our own start pulse cannot be a real result.
        if (alu_done && !start_q) begin
          a_d     = alu_result;
          err_d   = alu_err;
          state_d = SHOW;
        end else if (tmo_q == TW'(ALU_TIMEOUT)) begin
          a_d     = '0;
          err_d   = 1'b1;
          state_d = SHOW;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      SHOW: if (kev_q) begin
        if (is_digit) begin
          a_d = WIDTH'(dval); b_d = '0; bdig_d = 1'b0; err_d = 1'b0;
          state_d = ENTER_A;
        end else if (is_op) begin
          op_d = krow; b_d = '0; bdig_d = 1'b0; err_d = 1'b0;
          state_d = ENTER_B;
        end else if (is_clr) begin
          state_d = ENTER_A;
          a_d = '0; b_d = '0; op_d = '0; bdig_d = 1'b0; err_d = 1'b0;
        end
      end
      default: state_d = ENTER_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      bdig_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      bdig_q  <= bdig_d;
      err_q   <= err_d;
      start_q <= start_d;
      tmo_q   <= tmo_d;
    end
  end

  assign alu_start  = start_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign key_event  = kev_q;
  assign key_code   = kcode_q;
  assign disp_value = (state_q == ENTER_B && bdig_q) ? b_q : a_q;
  assign disp_err   = err_q;
  assign busy       = (state_q == WAIT);
endmodule

// File: tb/tb_keypad_calc_controller.sv
// Scoreboard bench: key presses queue expected key codes, equals presses queue
// expected ALU requests; a negedge monitor pops and compares on each strobe.
module tb_keypad_calc_controller;
  localparam int W   = 16;
  localparam int DEB = 4;
  localparam int REL = 12;
  localparam int TMO = 64;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic [3:0]   row_index = '0;
  logic [1:0]   col_index = '0;
  logic         alu_done = 1'b0, alu_err = 1'b0;
  logic [W-1:0] alu_result = '0;
  logic         alu_start, key_event, disp_err, busy;
  logic [W-1:0] alu_a, alu_b, disp_value;
  logic [1:0]   alu_op;
  logic [3:0]   key_code;

  typedef struct packed {logic [W-1:0] a; logic [W-1:0] b; logic [1:0] op;} alu_exp_t;
  alu_exp_t   q_alu[$];
  logic [3:0] q_key[$];
  int n_vec = 0, n_err = 0, kev_cnt = 0, start_cnt = 0;

  keypad_calc_controller #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .RELEASE_CYCLES(REL),
                           .ALU_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .row_index(row_index),
    .col_index(col_index), .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .key_event(key_event), .key_code(key_code), .disp_value(disp_value),
    .disp_err(disp_err), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (key_event) begin
      kev_cnt++;
      if (q_key.size() == 0) chk("kev_unexpected", 32'd1, 32'd0);
      else chk("key_code", 32'(key_code), 32'(q_key.pop_front()));
    end
    if (alu_start) begin
      start_cnt++;
      if (q_alu.size() == 0) chk("start_unexpected", 32'd1, 32'd0);
      else begin
        alu_exp_t e;
        e = q_alu.pop_front();
        chk("alu_a", 32'(alu_a), 32'(e.a));
        chk("alu_b", 32'(alu_b), 32'(e.b));
        chk("alu_op", 32'(alu_op), 32'(e.op));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] c);
    q_key.push_back(c);
    row_index = {2'b00, c[3:2]};
    col_index = c[1:0];
    key_valid = 1'b1;
    cyc(DEB + 2);
    key_valid = 1'b0;
    cyc(REL + 3);
  endtask

  task automatic press_eq(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    q_alu.push_back('{a: a, b: b, op: op});
    press(4'd14);
  endtask

  task automatic alu_reply(input logic [W-1:0] r, input logic e);
    alu_result = r;
    alu_err    = e;
    alu_done   = 1'b1;
    cyc(1);
    alu_done   = 1'b0;
    cyc(1);
  endtask

  task automatic chk_disp(input string tag, input logic [W-1:0] v, input logic e);
    @(negedge clk);
    chk({tag, "_disp"}, 32'(disp_value), 32'(v));
    chk({tag, "_err"}, 32'(disp_err), 32'(e));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k0, s0;
    cyc(3);
    @(negedge clk);
    chk("rst_disp", 32'(disp_value), 32'd0);
    chk("rst_start", 32'(alu_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_kev", 32'(key_event), 32'd0);
    chk("rst_kcode", 32'(key_code), 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // 2 + 3 = 5
    s0 = start_cnt;
    press(4'd1);  chk_disp("a2", 16'd2, 1'b0);
    press(4'd3);  chk_disp("op_add", 16'd2, 1'b0);
    press(4'd2);  chk_disp("b3", 16'd3, 1'b0);
    press_eq(16'd2, 16'd3, 2'd0);
    @(negedge clk); chk("wait_busy", 32'(busy), 32'd1);
    alu_reply(16'd5, 1'b0);
    chk_disp("res5", 16'd5, 1'b0);
    chk("busy_off", 32'(busy), 32'd0);
    chk("one_start", 32'(start_cnt - s0), 32'd1);

    // Bouncing then long-held press of code 5
    k0 = kev_cnt;
    q_key.push_back(4'd5);
    row_index = 4'd1; col_index = 2'd1;
    for (int i = 0; i < DEB - 1; i++) begin
      key_valid = 1'b1; cyc(1);
      key_valid = 1'b0; cyc(1);
    end
    key_valid = 1'b1; cyc(10 * 4 * 4);
    key_valid = 1'b0; cyc(REL + 3);
    chk("bounce_once", 32'(kev_cnt - k0), 32'd1);
    chk("bounce_code", 32'(key_code), 32'd5);
    chk_disp("show_digit", 16'd5, 1'b0);

    // Overflow rejection: 65536 -> 6553
    press(4'd12); chk_disp("clr", 16'd0, 1'b0);
    press(4'd6); press(4'd5); press(4'd5); press(4'd2);
    chk_disp("d6553", 16'd6553, 1'b0);
    press(4'd6);  chk_disp("ovf_reject", 16'd6553, 1'b0);

    // Operator replacement before B, ignored after B
    press(4'd7); press(4'd11);
    press(4'd1);  chk_disp("b2", 16'd2, 1'b0);
    press(4'd3);  chk_disp("op_ignored", 16'd2, 1'b0);
    press_eq(16'd6553, 16'd2, 2'd2);
    alu_reply(16'h1234, 1'b1);
    chk_disp("res_err", 16'h1234, 1'b1);

    // Chained operator, then timeout
    press(4'd3);  chk_disp("chain", 16'h1234, 1'b0);
    press(4'd0);  chk_disp("b1", 16'd1, 1'b0);
    press_eq(16'h1234, 16'd1, 2'd0);
    cyc(TMO + 16);
    chk_disp("timeout", 16'd0, 1'b1);
    chk("tmo_busy", 32'(busy), 32'd0);
    press(4'd12); chk_disp("clr_err", 16'd0, 1'b0);

    // Reset during WAIT, late done ignored
    press(4'd1); press(4'd3); press(4'd2);
    press_eq(16'd2, 16'd3, 2'd0);
    @(negedge clk); chk("wait2_busy", 32'(busy), 32'd1);
    cyc(0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_disp", 32'(disp_value), 32'd0);
    chk("mid_rst_ops", 32'({alu_a, alu_b}), 32'd0);
    chk("mid_rst_misc", 32'({alu_op, alu_start, key_event, key_code, disp_err}), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    alu_reply(16'h0055, 1'b1);
    chk_disp("late_done", 16'd0, 1'b0);
    chk("late_busy", 32'(busy), 32'd0);
    press(4'd1);  chk_disp("post_rst", 16'd2, 1'b0);

    chk("q_key_empty", 32'(q_key.size()), 32'd0);
    chk("q_alu_empty", 32'(q_alu.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
